core_imem_arbiter: RTL and testbench
====================================

Name: core_imem_arbiter

Overview:
- Shares one single-port instruction memory between two requesters: the instruction fetch stage and the program loader/debug port.
- Sequences each memory transaction with a req/ack handshake of variable latency, arbitrates with loader priority plus a fetch anti-starvation limit, and aborts transactions that exceed a timeout.
- Sits between the fetch stage, the loader and the instruction memory macro.

Parameters:
ADDR_W, 32, address width of all address ports
DATA_W, 32, data width of all data ports
STARVE_LIM, 4, max consecutive loader grants while a fetch request is pending (range 1..15)
TIMEOUT, 15, max cycles o_MemReq is held without i_MemAck before abort (range 1..255)

Ports:
i_Clk  in  1  clock, rising edge
i_Rst  in  1  reset, asynchronous, active-high
i_FetchReq  in  1  fetch request; held with address until o_FetchAck
i_FetchAddr  in  ADDR_W  fetch address, word aligned
i_FetchKill  in  1  flush: suppress the ack of the in-flight fetch
o_FetchAck  out  1  one-cycle pulse: o_FetchData valid
o_FetchData  out  DATA_W  fetched instruction
i_LdReq  in  1  loader request; held with its signals until o_LdAck
i_LdWe  in  1  loader write enable (1 = write, 0 = read)
i_LdAddr  in  ADDR_W  loader address
i_LdWData  in  DATA_W  loader write data
o_LdAck  out  1  one-cycle pulse: loader transaction done, o_LdRData valid on reads
o_LdRData  out  DATA_W  loader read data
o_MemReq  out  1  memory request, held until i_MemAck
o_MemWe  out  1  memory write enable
o_MemAddr  out  ADDR_W  memory address
o_MemWData  out  DATA_W  memory write data
i_MemAck  in  1  memory completion, sampled while o_MemReq = 1
i_MemRData  in  DATA_W  read data, valid when i_MemAck = 1
o_Event  out  1  one-cycle pulse: timeout abort

Behaviour:
- Reset (async, any state): state = IDLE, starvation and timeout counters = 0, kill flag = 0. All outputs are 0.
- All outputs are registered.
- States:
  - IDLE: evaluate requests.
  - BUSY_F: fetch transaction in flight.
  - BUSY_L: loader transaction in flight.
- IDLE arbitration, sampled on cycle n:
  - Loader only: go to BUSY_L.
  - Fetch only: go to BUSY_F.
  - Both, starvation count < STARVE_LIM: go to BUSY_L and increment the count.
  - Both, starvation count = STARVE_LIM: go to BUSY_F.
  - Any fetch grant clears the starvation count.
  - A loader grant with no pending fetch leaves the count unchanged.
  - On grant, cycle n+1: o_MemReq = 1, and o_MemAddr/o_MemWe/o_MemWData are loaded from the winner. For fetch, o_MemWe = 0 and o_MemWData = 0.
  - These memory signals stay stable until ack or abort.
- BUSY:
  - Timeout counter increments each cycle i_MemAck = 0.
  - On the cycle i_MemAck = 1: capture i_MemRData, return to IDLE, clear the counter.
  - Next cycle: o_MemReq = 0 and the requester ack pulses with its data. For fetch, the ack is suppressed if the kill flag is set.
- Minimum spacing is 2 cycles between consecutive o_MemReq assertions (one IDLE cycle).
- Timeout: if the counter reaches TIMEOUT with no ack, return to IDLE next cycle with o_MemReq = 0.
  - In that same cycle, o_Event = 1 and the requester ack pulses with data 0. For fetch, the ack is suppressed if killed.
  - An i_MemAck arriving after abort (o_MemReq = 0) is ignored.
- Kill:
  - i_FetchKill = 1 in BUSY_F sets the kill flag, which clears on return to IDLE.
  - i_FetchKill in IDLE blocks the fetch grant that cycle.
  - The memory transaction always completes; it is never cut short.
- A requester dropping its req mid-transaction does not abort the transaction; the ack still pulses.
- i_MemAck = 1 on the same cycle the counter reaches TIMEOUT: ack wins and no o_Event.
- o_FetchAck and o_LdAck are never high together.
- o_Event is never high with a successful ack.

Test Plan:
- Reset: with o_MemReq = 1 in BUSY_L, assert i_Rst mid-cycle -> all outputs 0 immediately. After release with no requests, the state stays IDLE.
- Single fetch: i_FetchAddr = 0x100 at cycle 0, memory acks at cycle 3 with 0x00500093 -> o_MemReq high cycles 1–3, o_MemAddr = 0x100, o_MemWe = 0; o_FetchAck = 1 at cycle 4 with o_FetchData = 0x00500093.
- Contention: both requesters held continuously with 1-cycle memory ack, STARVE_LIM = 4 -> grant order L,L,L,L,F,L,L,L,L,F. Loader write 0xDEADBEEF to 0x40 then read 0x40 -> o_LdRData = 0xDEADBEEF.
- Kill: fetch granted, i_FetchKill pulsed during BUSY_F, ack 2 cycles later -> no o_FetchAck. A following fetch to 0x104 acks normally.
- Timeout: TIMEOUT = 15, memory never acks -> o_MemReq held 15 cycles, then o_Event = 1 and o_FetchAck = 1 with data 0 in the same cycle. A late i_MemAck produces no further ack.
- Ack on the timeout boundary: i_MemAck arrives exactly when the counter reaches TIMEOUT -> normal ack with memory data, o_Event stays 0.

Source files
------------

// File: rtl/core_imem_arbiter.sv
// rtl/core_imem_arbiter.sv - shares one instruction memory port between fetch and loader
// Loader-priority arbitration with fetch anti-starvation, per-transaction timeout abort and fetch kill.
module core_imem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_LIM = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic              i_Clk,
  input  logic              i_Rst,
  input  logic              i_FetchReq,
  input  logic [ADDR_W-1:0] i_FetchAddr,
  input  logic              i_FetchKill,
  output logic              o_FetchAck,
  output logic [DATA_W-1:0] o_FetchData,
  input  logic              i_LdReq,
  input  logic              i_LdWe,
  input  logic [ADDR_W-1:0] i_LdAddr,
  input  logic [DATA_W-1:0] i_LdWData,
  output logic              o_LdAck,
  output logic [DATA_W-1:0] o_LdRData,
  output logic              o_MemReq,
  output logic              o_MemWe,
  output logic [ADDR_W-1:0] o_MemAddr,
  output logic [DATA_W-1:0] o_MemWData,
  input  logic              i_MemAck,
  input  logic [DATA_W-1:0] i_MemRData,
  output logic              o_Event
);

  typedef enum logic [1:0] {IDLE, BUSY_F, BUSY_L} state_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIM);

  state_t            state_q, state_d;
  logic [3:0]        starve_q, starve_d;
  logic [7:0]        tmo_q, tmo_d;
  logic              kill_q, kill_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              fetch_ack_q, fetch_ack_d;
  logic [DATA_W-1:0] fetch_data_q, fetch_data_d;
  logic              ld_ack_q, ld_ack_d;
  logic [DATA_W-1:0] ld_rdata_q, ld_rdata_d;
  logic              event_q, event_d;
  logic              fetch_ok;

  always_comb begin
    state_d      = state_q;
    starve_d     = starve_q;
    tmo_d        = tmo_q;
    kill_d       = kill_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    fetch_ack_d  = 1'b0;
    fetch_data_d = '0;
    ld_ack_d     = 1'b0;
    ld_rdata_d   = '0;
    event_d      = 1'b0;
    // A fetch being flushed this cycle is not a candidate for the grant.
    fetch_ok     = i_FetchReq && !i_FetchKill;

    case (state_q)
      IDLE: begin
        if (i_LdReq && (!fetch_ok || starve_q < STARVE_MAX)) begin
          state_d     = BUSY_L;
          mem_req_d   = 1'b1;
          mem_we_d    = i_LdWe;
          mem_addr_d  = i_LdAddr;
          mem_wdata_d = i_LdWData;
          if (fetch_ok) begin
            starve_d = starve_q + 4'd1;
          end
        end else if (fetch_ok) begin
          state_d     = BUSY_F;
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = i_FetchAddr;
          mem_wdata_d = '0;
          starve_d    = '0;
        end
      end
      BUSY_F, BUSY_L: begin
        if (state_q == BUSY_F && i_FetchKill) begin
          kill_d = 1'b1;
        end
        // An ack landing on the final allowed cycle beats the timeout.
        if (i_MemAck || tmo_q == TMO_LAST) begin
          state_d     = IDLE;
          tmo_d       = '0;
          kill_d      = 1'b0;
          mem_req_d   = 1'b0;
          mem_we_d    = 1'b0;
          mem_addr_d  = '0;
          mem_wdata_d = '0;
          event_d     = !i_MemAck;
          if (state_q == BUSY_F) begin
            fetch_ack_d  = !(kill_q || i_FetchKill);
            fetch_data_d = (i_MemAck && fetch_ack_d) ? i_MemRData : '0;
          end else begin
            ld_ack_d   = 1'b1;
            ld_rdata_d = i_MemAck ? i_MemRData : '0;
          end
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q      <= IDLE;
      starve_q     <= '0;
      tmo_q        <= '0;
      kill_q       <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      fetch_ack_q  <= 1'b0;
      fetch_data_q <= '0;
      ld_ack_q     <= 1'b0;
      ld_rdata_q   <= '0;
      event_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      starve_q     <= starve_d;
      tmo_q        <= tmo_d;
      kill_q       <= kill_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      fetch_ack_q  <= fetch_ack_d;
      fetch_data_q <= fetch_data_d;
      ld_ack_q     <= ld_ack_d;
      ld_rdata_q   <= ld_rdata_d;
      event_q      <= event_d;
    end
  end

  assign o_FetchAck  = fetch_ack_q;
  assign o_FetchData = fetch_data_q;
  assign o_LdAck     = ld_ack_q;
  assign o_LdRData   = ld_rdata_q;
  assign o_MemReq    = mem_req_q;
  assign o_MemWe     = mem_we_q;
  assign o_MemAddr   = mem_addr_q;
  assign o_MemWData  = mem_wdata_q;
  assign o_Event     = event_q;

endmodule

// File: tb/tb_core_imem_arbiter.sv
// tb/tb_core_imem_arbiter.sv - directed self-checking bench for core_imem_arbiter
module tb_core_imem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_FetchReq, i_FetchKill, i_LdReq, i_LdWe;
  logic [31:0] i_FetchAddr, i_LdAddr, i_LdWData;
  logic        o_FetchAck, o_LdAck, o_MemReq, o_MemWe, o_Event;
  logic [31:0] o_FetchData, o_LdRData, o_MemAddr, o_MemWData;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  logic        auto_en = 1'b0;
  int          ack_lat = 0;
  logic        man_ack = 1'b0;
  logic        auto_ack = 1'b0;
  logic [31:0] auto_rdata = '0;
  int          wait_cnt = 0;
  logic [31:0] mem [0:255];
  logic        both_ack_seen = 1'b0;

  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  core_imem_arbiter dut (
    .i_Clk(clk), .i_Rst(rst),
    .i_FetchReq(i_FetchReq), .i_FetchAddr(i_FetchAddr), .i_FetchKill(i_FetchKill),
    .o_FetchAck(o_FetchAck), .o_FetchData(o_FetchData),
    .i_LdReq(i_LdReq), .i_LdWe(i_LdWe), .i_LdAddr(i_LdAddr), .i_LdWData(i_LdWData),
    .o_LdAck(o_LdAck), .o_LdRData(o_LdRData),
    .o_MemReq(o_MemReq), .o_MemWe(o_MemWe), .o_MemAddr(o_MemAddr), .o_MemWData(o_MemWData),
    .i_MemAck(mem_ack), .i_MemRData(mem_rdata), .o_Event(o_Event)
  );

  assign mem_ack   = auto_ack | man_ack;
  assign mem_rdata = auto_ack ? auto_rdata : 32'hBAD0_0001;

  // Memory responder: acks ack_lat cycles after o_MemReq rises, backed by a small array.
  always @(negedge clk) begin
    if (rst) begin
      mem[64] = 32'h0050_0093;
      mem[65] = 32'h00A0_0113;
    end
    if (auto_en && o_MemReq) begin
      if (wait_cnt >= ack_lat) begin
        auto_ack   = 1'b1;
        auto_rdata = mem[o_MemAddr[9:2]];
        if (o_MemWe) mem[o_MemAddr[9:2]] = o_MemWData;
        wait_cnt   = 0;
      end else begin
        auto_ack = 1'b0;
        wait_cnt = wait_cnt + 1;
      end
    end else begin
      auto_ack   = 1'b0;
      auto_rdata = '0;
      wait_cnt   = 0;
    end
    if (o_FetchAck && o_LdAck) both_ack_seen = 1'b1;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fetch_ack(input int max_cyc, output logic seen, output logic [31:0] data);
    seen = 1'b0;
    data = '0;
    for (int i = 0; i < max_cyc; i++) begin
      step();
      if (o_FetchAck) begin
        seen = 1'b1;
        data = o_FetchData;
        break;
      end
    end
  endtask

  task automatic ld_xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         output logic seen, output logic [31:0] rdata,
                         output logic we_seen, output logic [31:0] wd_seen);
    seen = 1'b0; rdata = '0; we_seen = 1'b0; wd_seen = '0;
    i_LdReq = 1'b1; i_LdWe = we; i_LdAddr = addr; i_LdWData = wdata;
    for (int i = 0; i < 40; i++) begin
      step();
      if (o_MemReq) begin
        we_seen = o_MemWe;
        wd_seen = o_MemWData;
      end
      if (o_LdAck) begin
        seen  = 1'b1;
        rdata = o_LdRData;
        break;
      end
    end
    i_LdReq = 1'b0; i_LdWe = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        seen, we_seen, prev, any_ack;
    logic [31:0] d, wd;
    logic [9:0]  grant_bits;
    int          ng, hi;

    rst = 1'b1;
    i_FetchReq = 1'b0; i_FetchKill = 1'b0; i_FetchAddr = '0;
    i_LdReq = 1'b0; i_LdWe = 1'b0; i_LdAddr = '0; i_LdWData = '0;
    step(); step();
    check_eq("rst_mem_req", 64'(o_MemReq), 64'd0);
    check_eq("rst_pulses", 64'({o_FetchAck, o_LdAck, o_Event}), 64'd0);
    check_eq("rst_mem_addr", 64'(o_MemAddr), 64'd0);
    rst = 1'b0;
    repeat (3) step();
    check_eq("idle_no_req", 64'(o_MemReq), 64'd0);

    // Single fetch, memory acks on cycle 3
    auto_en = 1'b1; ack_lat = 2;
    i_FetchReq = 1'b1; i_FetchAddr = 32'h100;
    step();
    check_eq("f1_req_c1", 64'(o_MemReq), 64'd1);
    check_eq("f1_addr", 64'(o_MemAddr), 64'h100);
    check_eq("f1_we", 64'(o_MemWe), 64'd0);
    step();
    check_eq("f1_req_c2", 64'(o_MemReq), 64'd1);
    step();
    check_eq("f1_req_c3", 64'({o_MemReq, o_FetchAck}), 64'b10);
    step();
    check_eq("f1_ack_c4", 64'({o_MemReq, o_FetchAck}), 64'b01);
    check_eq("f1_data", 64'(o_FetchData), 64'h0050_0093);
    i_FetchReq = 1'b0;
    step();
    check_eq("f1_ack_pulse", 64'(o_FetchAck), 64'd0);

    // Contention with 1-cycle ack: expect L,L,L,L,F,L,L,L,L,F (1 = fetch)
    ack_lat = 0;
    i_FetchReq = 1'b1; i_FetchAddr = 32'h200;
    i_LdReq = 1'b1; i_LdWe = 1'b0; i_LdAddr = 32'h10;
    grant_bits = '0; ng = 0; prev = o_MemReq;
    for (int i = 0; i < 60 && ng < 10; i++) begin
      step();
      if (o_MemReq && !prev) begin
        grant_bits = {grant_bits[8:0], (o_MemAddr == 32'h200)};
        ng++;
      end
      prev = o_MemReq;
    end
    i_FetchReq = 1'b0; i_LdReq = 1'b0;
    check_eq("cont_grants", 64'(ng), 64'd10);
    check_eq("cont_order", 64'(grant_bits), 64'b00001_00001);
    repeat (3) step();

    // Loader write then read back
    ld_xfer(1'b1, 32'h40, 32'hDEAD_BEEF, seen, d, we_seen, wd);
    check_eq("ldw_ack", 64'(seen), 64'd1);
    check_eq("ldw_we", 64'(we_seen), 64'd1);
    check_eq("ldw_wdata", 64'(wd), 64'hDEAD_BEEF);
    ld_xfer(1'b0, 32'h40, 32'h0, seen, d, we_seen, wd);
    check_eq("ldr_ack", 64'(seen), 64'd1);
    check_eq("ldr_we", 64'(we_seen), 64'd0);
    check_eq("ldr_data", 64'(d), 64'hDEAD_BEEF);

    // Kill during BUSY_F, ack two cycles later is swallowed
    ack_lat = 2;
    i_FetchReq = 1'b1; i_FetchAddr = 32'h300;
    step();
    check_eq("kill_busy", 64'(o_MemReq), 64'd1);
    i_FetchKill = 1'b1;
    step();
    i_FetchKill = 1'b0; i_FetchReq = 1'b0;
    step();
    step();
    check_eq("kill_done", 64'(o_MemReq), 64'd0);
    check_eq("kill_no_ack", 64'(o_FetchAck), 64'd0);
    step();
    check_eq("kill_no_late_ack", 64'(o_FetchAck), 64'd0);

    // Kill in IDLE blocks the grant; the next fetch acks normally
    i_FetchReq = 1'b1; i_FetchAddr = 32'h104; i_FetchKill = 1'b1;
    step();
    check_eq("kill_idle_block", 64'(o_MemReq), 64'd0);
    i_FetchKill = 1'b0;
    wait_fetch_ack(20, seen, d);
    i_FetchReq = 1'b0;
    check_eq("f104_ack", 64'(seen), 64'd1);
    check_eq("f104_data", 64'(d), 64'h00A0_0113);
    step();

    // Timeout: memory never acks
    auto_en = 1'b0;
    i_FetchReq = 1'b1; i_FetchAddr = 32'h500; hi = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (o_MemReq) hi++;
      else break;
    end
    check_eq("tmo_req_cycles", 64'(hi), 64'd15);
    check_eq("tmo_event", 64'(o_Event), 64'd1);
    check_eq("tmo_fetch_ack", 64'(o_FetchAck), 64'd1);
    check_eq("tmo_data", 64'(o_FetchData), 64'd0);
    i_FetchReq = 1'b0; man_ack = 1'b1;
    step();
    man_ack = 1'b0;
    check_eq("tmo_event_pulse", 64'(o_Event), 64'd0);
    any_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      any_ack = any_ack | o_FetchAck | o_LdAck | o_MemReq | o_Event;
      step();
    end
    check_eq("late_ack_ignored", 64'(any_ack), 64'd0);

    // Ack exactly on the timeout boundary wins
    auto_en = 1'b1; ack_lat = 14;
    i_FetchReq = 1'b1; i_FetchAddr = 32'h100; hi = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (o_MemReq) hi++;
      else break;
    end
    check_eq("bnd_req_cycles", 64'(hi), 64'd15);
    check_eq("bnd_no_event", 64'(o_Event), 64'd0);
    check_eq("bnd_ack", 64'(o_FetchAck), 64'd1);
    check_eq("bnd_data", 64'(o_FetchData), 64'h0050_0093);
    i_FetchReq = 1'b0;
    step();

    // Asynchronous reset while a loader transaction is in flight
    auto_en = 1'b0;
    i_LdReq = 1'b1; i_LdWe = 1'b0; i_LdAddr = 32'h40;
    step();
    check_eq("rstmid_busy", 64'(o_MemReq), 64'd1);
    #2 rst = 1'b1;
    #1;
    check_eq("rstmid_req", 64'(o_MemReq), 64'd0);
    check_eq("rstmid_addr", 64'(o_MemAddr), 64'd0);
    check_eq("rstmid_misc", 64'({o_MemWe, o_FetchAck, o_LdAck, o_Event,
                                 |o_MemWData, |o_FetchData, |o_LdRData}), 64'd0);
    i_LdReq = 1'b0;
    step();
    rst = 1'b0;
    repeat (3) step();
    check_eq("post_rst_idle", 64'(o_MemReq), 64'd0);

    check_eq("ack_exclusive", 64'(both_ack_seen), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
